// File: rtl/scie_cfir_param.sv
// Complex FIR coprocessor: loadable complex taps, a delay line fed by PUSH, and a
// tap-serial complex MAC whose scaled, saturated or wrapped result lands in io_rd_*.
module scie_cfir_param #(
    parameter int W    = 16,
    parameter int TAPS = 4,
    parameter int FRAC = 0,
    parameter int SAT  = 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                io_valid,
    input  logic [31:0]         io_insn,
    input  logic signed [W-1:0] io_rs1_real,
    input  logic signed [W-1:0] io_rs1_imag,
    input  logic [31:0]         io_rs2,
    output logic signed [W-1:0] io_rd_real,
    output logic signed [W-1:0] io_rd_imag,
    output logic                io_busy,
    output logic                io_done,
    output logic                io_err
);
    localparam int KW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int AW = 2 * W + $clog2(TAPS) + 1;

    localparam logic [6:0] OP_LOAD  = 7'h0B;
    localparam logic [6:0] OP_PUSH  = 7'h2B;
    localparam logic [6:0] OP_CLEAR = 7'h7B;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t state, state_next;

    logic signed [W-1:0]  coef_re [TAPS];
    logic signed [W-1:0]  coef_im [TAPS];
    logic signed [W-1:0]  x_re    [TAPS];
    logic signed [W-1:0]  x_im    [TAPS];
    logic [KW-1:0]        k;
    logic signed [AW-1:0] acc_re, acc_im;

    logic [6:0] op;
    logic       is_load, is_push, is_clear, busy, rs2_ok;
    logic       load_ok, push_ok, clear_ok, err_set, last_tap;
    logic       unused_insn;

    assign op          = io_insn[6:0];
    assign unused_insn = ^io_insn[31:7];
    assign busy        = (state != IDLE);
    assign io_busy     = busy;
    assign is_load     = io_valid && (op == OP_LOAD);
    assign is_push     = io_valid && (op == OP_PUSH);
    assign is_clear    = io_valid && (op == OP_CLEAR);
    assign rs2_ok      = (io_rs2 < 32'(TAPS));
    assign load_ok     = is_load && !busy && rs2_ok;
    assign push_ok     = is_push && !busy;
    assign clear_ok    = is_clear && !busy;
    assign err_set     = (is_load && (busy || !rs2_ok)) || ((is_push || is_clear) && busy);
    assign last_tap    = (k == KW'(TAPS - 1));

    logic signed [W-1:0]   cr, ci, xr, xi;
    logic signed [2*W-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [AW-1:0]  acc_re_next, acc_im_next, sh_re, sh_im;

    always_comb begin
        cr   = coef_re[k];
        ci   = coef_im[k];
        xr   = x_re[k];
        xi   = x_im[k];
        p_rr = (2*W)'(cr) * (2*W)'(xr);
        p_ii = (2*W)'(ci) * (2*W)'(xi);
        p_ri = (2*W)'(cr) * (2*W)'(xi);
        p_ir = (2*W)'(ci) * (2*W)'(xr);
        acc_re_next = acc_re + AW'(p_rr) - AW'(p_ii);
        acc_im_next = acc_im + AW'(p_ri) + AW'(p_ir);
        sh_re = acc_re >>> FRAC;
        sh_im = acc_im >>> FRAC;
    end

    // Out of range when the bits above the W-bit sign position disagree with it.
    function automatic logic [W-1:0] fit(input logic signed [AW-1:0] v);
        if (SAT != 0 && !((&v[AW-1:W-1]) || !(|v[AW-1:W-1])))
            fit = v[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        else
            fit = v[W-1:0];
    endfunction

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (push_ok) state_next = MAC;
            MAC:     if (last_tap) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            k          <= '0;
            acc_re     <= '0;
            acc_im     <= '0;
            io_rd_real <= '0;
            io_rd_imag <= '0;
            io_done    <= 1'b0;
            io_err     <= 1'b0;
            for (int unsigned i = 0; i < TAPS; i++) begin
                coef_re[i] <= '0;
                coef_im[i] <= '0;
                x_re[i]    <= '0;
                x_im[i]    <= '0;
            end
        end else begin
            state   <= state_next;
            io_done <= 1'b0;
            if (err_set)
                io_err <= 1'b1;
            else if (clear_ok)
                io_err <= 1'b0;
            if (load_ok) begin
                coef_re[io_rs2[KW-1:0]] <= io_rs1_real;
                coef_im[io_rs2[KW-1:0]] <= io_rs1_imag;
            end
            if (push_ok) begin
                for (int unsigned i = 1; i < TAPS; i++) begin
                    x_re[i] <= x_re[i-1];
                    x_im[i] <= x_im[i-1];
                end
                x_re[0] <= io_rs1_real;
                x_im[0] <= io_rs1_imag;
                acc_re  <= '0;
                acc_im  <= '0;
                k       <= '0;
            end
            if (clear_ok) begin
                for (int unsigned i = 0; i < TAPS; i++) begin
                    x_re[i] <= '0;
                    x_im[i] <= '0;
                end
                acc_re     <= '0;
                acc_im     <= '0;
                io_rd_real <= '0;
                io_rd_imag <= '0;
            end
            case (state)
                MAC: begin
                    acc_re <= acc_re_next;
                    acc_im <= acc_im_next;
                    k      <= last_tap ? '0 : k + 1'b1;
                end
                DONE: begin
                    io_rd_real <= fit(sh_re);
                    io_rd_imag <= fit(sh_im);
                    io_done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
